// File: rtl/instr_loader.sv
// instr_loader: streams machine-code words from a valid/ready source into an
// instruction memory at consecutive addresses starting from 0.
// The optional trailing checksum word is enabled by defining LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int D = 12,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D:0]   load_len,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic         err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  // Largest legal length is the full memory depth, 2**D.
  localparam logic [D:0] LEN_MAX = {1'b1, {D{1'b0}}};
  localparam logic [D:0] LEN_ONE = {{D{1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [D-1:0] addr_q, addr_d;
  logic [D:0]   len_q, len_d;
  logic         wr_en_q, wr_en_d;
  logic [D-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0] wr_data_q, wr_data_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [W-1:0] sum_q, sum_d;
`endif

  logic beat;
  logic last_beat;
  logic len_ok;

  // Handshake and length qualification derived from the current state.
  always_comb begin
    in_ready = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    in_ready = (state_q == LOAD) || (state_q == CHK);
`else
    in_ready = (state_q == LOAD);
`endif
    beat      = in_valid && in_ready;
    last_beat = ({1'b0, addr_q} == (len_q - LEN_ONE));
    len_ok    = (load_len != '0) && (load_len <= LEN_MAX);
  end

  // Next-state and registered-output logic; the counter stops on the last
  // address instead of incrementing, so it never wraps past 2**D-1.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d = LOAD;
            addr_d  = '0;
            len_d   = load_len;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = in_data;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = sum_q ^ in_data;
`endif
          if (last_beat) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
            done_d  = 1'b1;
`endif
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (beat) begin
          state_d = DONE;
          if (in_data == sum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table-driven and randomized checks of instr_loader.
// Expected writes come from the loaded word list itself: word k must land at
// address k exactly once, with one done (or err) per load.
`timescale 1ns/1ps
module tb_instr_loader;
  localparam int D     = 12;
  localparam int W     = 9;
  localparam int DEPTH = 1 << D;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [D:0]   load_len;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         busy;
  logic         done;
  logic         err;

  instr_loader #(.D(D), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .load_len (load_len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [D-1:0] addr;
    logic [W-1:0] data;
    int           cyc;
    logic         done_too;
  } wr_rec_t;

  typedef struct {
    int         len;
    int         gap;
    int         mid_start;
    logic [D:0] mid_len;
    int         exp_writes;
    int         exp_done;
    int         exp_err;
  } vec_t;

  wr_rec_t      obs_q[$];
  int           done_cnt = 0;
  int           err_cnt  = 0;
  int           cyc_cnt  = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  int           last_base;
  logic [W-1:0] words[$];

  // Passive monitor: records every write strobe and every done/err pulse.
  always @(negedge clk) begin
    cyc_cnt++;
    if (wr_en === 1'b1) obs_q.push_back('{addr: wr_addr, data: wr_data, cyc: cyc_cnt, done_too: done});
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one start plus its word stream and checks the resulting writes.
  // gap: 0 = in_valid held high, 1 = toggling 1,0,1,..., 2 = random.
  task automatic applyStimulus(input string tag, input int len, input int gap,
                               input int mid_start, input logic [D:0] mid_len,
                               input bit chk_bad, input bit fixed_words,
                               input int exp_writes, input int exp_done, input int exp_err);
    int base, d0, e0, i, budget, busy_drops, toggle, nbad;
    bit acc, v;
    logic [W-1:0] sum, ck;
    if (!fixed_words) begin
      words.delete();
      for (int k = 0; k < exp_writes; k++) words.push_back(W'($urandom));
    end
    base = obs_q.size();
    last_base = base;
    d0 = done_cnt;
    e0 = err_cnt;
    busy_drops = 0;
    start = 1'b1;
    load_len = len[D:0];
    tick();
    start = 1'b0;
    load_len = (D+1)'($urandom);
    if (exp_writes == 0) begin
      checkOutput({tag, "_err_next_cycle"}, {31'd0, err}, 1);
      for (int k = 0; k < 3; k++) begin
        if (busy !== 1'b0 || in_ready !== 1'b0) busy_drops++;
        tick();
      end
      checkOutput({tag, "_busy_low"}, busy_drops, 0);
    end else begin
      i = 0;
      budget = 4 * exp_writes + 50;
      toggle = 1;
      while (i < exp_writes && budget > 0) begin
        case (gap)
          0:       v = 1'b1;
          1:       v = toggle[0];
          default: v = $urandom_range(0, 1) == 1;
        endcase
        toggle ^= 1;
        in_valid = v;
        in_data = v ? words[i] : W'($urandom);
        if (i == mid_start) begin
          start = 1'b1;
          load_len = mid_len;
        end
        if (busy !== 1'b1) busy_drops++;
        acc = v && (in_ready === 1'b1);
        tick();
        start = 1'b0;
        if (acc) i++;
        budget--;
      end
      in_valid = 1'b0;
      checkOutput({tag, "_beats_accepted"}, i, exp_writes);
`ifdef LOADER_CHECKSUM_EN
      sum = '0;
      for (int k = 0; k < exp_writes; k++) sum ^= words[k];
      ck = chk_bad ? (sum ^ W'(3)) : sum;
      acc = 1'b0;
      budget = 50;
      while (!acc && budget > 0) begin
        in_valid = 1'b1;
        in_data = ck;
        acc = (in_ready === 1'b1);
        tick();
        budget--;
      end
      in_valid = 1'b0;
      checkOutput({tag, "_chk_beat"}, {31'd0, acc}, 1);
`else
      sum = '0;
      ck = sum;
`endif
      tick();
      tick();
      tick();
      checkOutput({tag, "_busy_held"}, busy_drops, 0);
      checkOutput({tag, "_idle_after"}, {30'd0, busy, in_ready}, 0);
    end
    checkOutput({tag, "_write_count"}, obs_q.size() - base, exp_writes);
    nbad = 0;
    for (int k = 0; k < exp_writes && base + k < obs_q.size(); k++) begin
      if (obs_q[base+k].addr !== D'(k) || obs_q[base+k].data !== words[k]) nbad++;
    end
    checkOutput({tag, "_write_content_bad"}, nbad, 0);
    checkOutput({tag, "_done_pulses"}, done_cnt - d0, chk_bad ? 0 : exp_done);
    checkOutput({tag, "_err_pulses"}, err_cnt - e0, chk_bad ? 1 : exp_err);
`ifndef LOADER_CHECKSUM_EN
    if (exp_writes > 0 && obs_q.size() == base + exp_writes)
      checkOutput({tag, "_done_with_last_write"}, {31'd0, obs_q[base+exp_writes-1].done_too}, 1);
`endif
  endtask

  vec_t vecs[8];

  initial begin
    int base, d0, i, budget, len;
    bit acc;
    reset = 1'b1;
    start = 1'b0;
    load_len = '0;
    in_valid = 1'b0;
    in_data = '0;

    vecs[0] = '{len: 3,         gap: 0, mid_start: -1, mid_len: 0, exp_writes: 3, exp_done: 1, exp_err: 0};
    vecs[1] = '{len: 4,         gap: 1, mid_start: -1, mid_len: 0, exp_writes: 4, exp_done: 1, exp_err: 0};
    vecs[2] = '{len: 1,         gap: 0, mid_start: -1, mid_len: 0, exp_writes: 1, exp_done: 1, exp_err: 0};
    vecs[3] = '{len: 2,         gap: 1, mid_start: 0,  mid_len: 5, exp_writes: 2, exp_done: 1, exp_err: 0};
    vecs[4] = '{len: 7,         gap: 2, mid_start: 3,  mid_len: 0, exp_writes: 7, exp_done: 1, exp_err: 0};
    vecs[5] = '{len: 0,         gap: 0, mid_start: -1, mid_len: 0, exp_writes: 0, exp_done: 0, exp_err: 1};
    vecs[6] = '{len: DEPTH + 1, gap: 0, mid_start: -1, mid_len: 0, exp_writes: 0, exp_done: 0, exp_err: 1};
    vecs[7] = '{len: 2*DEPTH-1, gap: 0, mid_start: -1, mid_len: 0, exp_writes: 0, exp_done: 0, exp_err: 1};

    tick();
    tick();
    checkOutput("reset_flags", {27'd0, in_ready, wr_en, busy, done, err}, 0);
    checkOutput("reset_wr_addr", {20'd0, wr_addr}, 0);
    checkOutput("reset_wr_data", {23'd0, wr_data}, 0);
    reset = 1'b0;
    tick();

    // Exact three-word load with continuous valid: consecutive writes, done on the third.
    words.delete();
    words.push_back(9'h0FE);
    words.push_back(9'h066);
    words.push_back(9'h07A);
    applyStimulus("basic3", 3, 0, -1, '0, 1'b0, 1'b1, 3, 1, 0);
    if (obs_q.size() >= last_base + 3) begin
      checkOutput("basic3_w0_data", {23'd0, obs_q[last_base].data}, 32'h0FE);
      checkOutput("basic3_w2_addr", {20'd0, obs_q[last_base+2].addr}, 2);
      checkOutput("basic3_consecutive", obs_q[last_base+2].cyc - obs_q[last_base].cyc, 2);
    end else begin
      checkOutput("basic3_write_seen", obs_q.size() - last_base, 3);
    end

    // Table of lengths, valid patterns and ignored mid-load starts.
    for (int t = 0; t < 8; t++) begin
      applyStimulus($sformatf("vec%0d", t), vecs[t].len, vecs[t].gap, vecs[t].mid_start,
                    vecs[t].mid_len, 1'b0, 1'b0, vecs[t].exp_writes, vecs[t].exp_done, vecs[t].exp_err);
    end

    // Reset after two of five words: everything clears, nothing more is written.
    words.delete();
    for (int k = 0; k < 5; k++) words.push_back(W'($urandom));
    base = obs_q.size();
    d0 = done_cnt;
    start = 1'b1;
    load_len = 5;
    tick();
    start = 1'b0;
    i = 0;
    budget = 20;
    while (i < 2 && budget > 0) begin
      in_valid = 1'b1;
      in_data = words[i];
      acc = (in_ready === 1'b1);
      tick();
      if (acc) i++;
      budget--;
    end
    checkOutput("rst_mid_beats", i, 2);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("rst_mid_flags", {27'd0, in_ready, wr_en, busy, done, err}, 0);
    checkOutput("rst_mid_addr_data", {11'd0, wr_addr, wr_data}, 0);
    reset = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    checkOutput("rst_mid_writes", obs_q.size() - base, 2);
    checkOutput("rst_mid_no_done", done_cnt - d0, 0);
    if (obs_q.size() >= base + 2)
      checkOutput("rst_mid_second_addr", {20'd0, obs_q[base+1].addr}, 1);
    applyStimulus("after_rst", 5, 0, -1, '0, 1'b0, 1'b0, 5, 1, 0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum word matching and not matching the XOR of the loaded words.
    words.delete();
    words.push_back(9'h001);
    words.push_back(9'h002);
    applyStimulus("chk_good", 2, 0, -1, '0, 1'b0, 1'b1, 2, 1, 0);
    applyStimulus("chk_bad", 2, 0, -1, '0, 1'b1, 1'b1, 2, 1, 0);
`endif

    // Full-depth load: last write at 2**D-1, start mid-load ignored.
    applyStimulus("full", DEPTH, 0, 100, 3, 1'b0, 1'b0, DEPTH, 1, 0);
    if (obs_q.size() >= last_base + DEPTH)
      checkOutput("full_last_addr", {20'd0, obs_q[last_base+DEPTH-1].addr}, DEPTH - 1);

    // Randomized loads with random valid gaps and random mid-load starts.
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 24);
      applyStimulus($sformatf("rand%0d", r), len, 2, $urandom_range(0, len - 1),
                    (D+1)'($urandom_range(0, 6)), 1'b0, 1'b0, len, 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
